// File: rtl/fp_expand_pkg.sv
// Shared widths and sample typedef for the float/linear converter pair.
// Combinational helper only; no state.
package fpcvt_pkg;

  localparam int LIN_W = 12;
  localparam int MAG_W = 11;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [SIG_W-1:0] significand;
  } fp_sample_t;

  // Negative zero comes out as 0x000 naturally from the two's-complement negate.
  function automatic logic [LIN_W-1:0] apply_sign(input logic sign, input logic [MAG_W-1:0] mag);
    logic [LIN_W-1:0] ext;
    ext = {1'b0, mag};
    return sign ? (~ext + LIN_W'(1)) : ext;
  endfunction

endpackage

// File: rtl/fp_expand_if.sv
// Stream bundle for fp_expand: float sample in, linear sample and emitted count out.
// slave = the expander, master = the upstream/downstream environment.
interface fp_expand_if #(
  parameter int CNT_W = 16
);
  import fpcvt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exponent;
  logic [SIG_W-1:0] in_significand;
  logic             out_valid;
  logic             out_ready;
  logic [LIN_W-1:0] out_linear;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_sign, in_exponent, in_significand, out_ready,
    output in_ready, out_valid, out_linear, out_count
  );

  modport master (
    output in_valid, in_sign, in_exponent, in_significand, out_ready,
    input  in_ready, out_valid, out_linear, out_count
  );

endinterface

// File: rtl/fp_mag_decode.sv
// Exponent/significand to 11-bit magnitude, optional half-LSB midpoint term.
// Purely combinational; max result 1984 so no overflow handling is needed.
module fp_mag_decode
  import fpcvt_pkg::*;
#(
  parameter bit MIDPOINT = 1'b0
) (
  input  logic [EXP_W-1:0] exponent_i,
  input  logic [SIG_W-1:0] significand_i,
  output logic [MAG_W-1:0] mag_o
);

  logic [MAG_W-1:0] base;
  logic [MAG_W-1:0] half;

  always_comb begin
    base = MAG_W'(significand_i) << exponent_i;
    half = '0;
    // At exponent 0 no bits were discarded, so there is no midpoint to add.
    if (MIDPOINT && (exponent_i != '0)) begin
      half = MAG_W'(1) << (exponent_i - EXP_W'(1));
    end
    mag_o = base + half;
  end

endmodule

// File: rtl/fp_expand.sv
// Two-stage float-to-linear expander: S1 decodes magnitude, S2 applies sign.
// Latency 2 edges, 1 sample/cycle; out_ready feeds in_ready combinationally.
module fp_expand
  import fpcvt_pkg::*;
#(
  parameter bit MIDPOINT = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_expand_if.slave bus
);

  fp_sample_t       in_smp;
  logic             s2_load;
  logic             s1_adv;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic [MAG_W-1:0] dec_mag;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [MAG_W-1:0] s1_mag_q,   s1_mag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [LIN_W-1:0] s2_lin_q,   s2_lin_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  assign in_smp = {bus.in_sign, bus.in_exponent, bus.in_significand};

  fp_mag_decode #(
    .MIDPOINT (MIDPOINT)
  ) u_dec (
    .exponent_i    (in_smp.exponent),
    .significand_i (in_smp.significand),
    .mag_o         (dec_mag)
  );

  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = s2_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s2_valid_d = s2_valid_q;
    s2_lin_d   = s2_lin_q;
    cnt_d      = cnt_q;

    // A new input may land in S1 on the same edge S1 drains into S2.
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_sign_d  = in_smp.sign;
      s1_mag_d   = dec_mag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_lin_d = apply_sign(s1_sign_q, s1_mag_q);
      end
    end

    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_lin_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_lin_q   <= s2_lin_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_linear = s2_lin_q;
  assign bus.out_count  = cnt_q;

endmodule

// File: tb/tb_fp_expand.sv
// Directed-vector bench for fp_expand: dut0 MIDPOINT=0/CNT_W=4, dut1 MIDPOINT=1/CNT_W=16.
module tb_fp_expand;
  import fpcvt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_expand_if #(.CNT_W(4))  bus0 ();
  fp_expand_if #(.CNT_W(16)) bus1 ();

  fp_expand #(.MIDPOINT(1'b0), .CNT_W(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fp_expand #(.MIDPOINT(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit         mp;
    logic       s;
    logic [2:0] e;
    logic [3:0] m;
    logic [11:0] lin;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic s, input logic [2:0] e, input logic [3:0] m);
    if (sel) begin
      bus1.in_valid = v; bus1.in_sign = s; bus1.in_exponent = e; bus1.in_significand = m;
    end else begin
      bus0.in_valid = v; bus0.in_sign = s; bus0.in_exponent = e; bus0.in_significand = m;
    end
  endtask

  function automatic logic get_vld(input bit sel);
    return sel ? bus1.out_valid : bus0.out_valid;
  endfunction

  function automatic logic [11:0] get_lin(input bit sel);
    return sel ? bus1.out_linear : bus0.out_linear;
  endfunction

  function automatic logic [15:0] get_cnt(input bit sel);
    return sel ? bus1.out_count : {12'd0, bus0.out_count};
  endfunction

  function automatic logic [11:0] model(input bit mp, input logic s, input logic [2:0] e, input logic [3:0] m);
    int mag;
    mag = int'(m) * (1 << e);
    if (mp && e != 3'd0) mag += 1 << (e - 3'd1);
    if (s) mag = -mag;
    return mag[11:0];
  endfunction

  logic [11:0] q[$];
  logic        rs, rv;
  logic [2:0]  re;
  logic [3:0]  rm;
  logic [11:0] prev_lin;
  logic [3:0]  ntx;
  logic [15:0] cnt_exp0, cnt_exp1, cnt_before;
  bit          hold_pending, wrap_pending, wrap_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b0, 1'b0, 3'd7, 4'd15, 12'h780};
    vec[1]  = '{1'b0, 1'b1, 3'd7, 4'd15, 12'h880};
    vec[2]  = '{1'b0, 1'b0, 3'd0, 4'd5,  12'h005};
    vec[3]  = '{1'b0, 1'b1, 3'd3, 4'd0,  12'h000};
    vec[4]  = '{1'b0, 1'b0, 3'd4, 4'd1,  12'h010};
    vec[5]  = '{1'b0, 1'b1, 3'd0, 4'd1,  12'hFFF};
    vec[6]  = '{1'b0, 1'b0, 3'd1, 4'd15, 12'h01E};
    vec[7]  = '{1'b0, 1'b1, 3'd2, 4'd3,  12'hFF4};
    vec[8]  = '{1'b1, 1'b0, 3'd3, 4'd9,  12'h04C};
    vec[9]  = '{1'b1, 1'b1, 3'd0, 4'd9,  12'hFF7};
    vec[10] = '{1'b1, 1'b0, 3'd7, 4'd15, 12'h7C0};
    vec[11] = '{1'b1, 1'b1, 3'd7, 4'd15, 12'h840};
    vec[12] = '{1'b1, 1'b0, 3'd1, 4'd0,  12'h001};
    vec[13] = '{1'b1, 1'b1, 3'd3, 4'd0,  12'hFFC};
    vec[14] = '{1'b1, 1'b0, 3'd0, 4'd0,  12'h000};

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_vld%0d", d), get_vld(d[0]), 0);
      chk($sformatf("rst_lin%0d", d), get_lin(d[0]), 0);
      chk($sformatf("rst_cnt%0d", d), get_cnt(d[0]), 0);
    end
    chk("rst_in_rdy0", bus0.in_ready, 1);
    chk("rst_in_rdy1", bus1.in_ready, 1);

    // Single-sample vectors with latency and count checks
    cnt_exp0 = 0;
    cnt_exp1 = 0;
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].mp, 1, vec[i].s, vec[i].e, vec[i].m);
      @(negedge clk);
      drive(vec[i].mp, 0, 0, 0, 0);
      chk($sformatf("v%0d_early", i), get_vld(vec[i].mp), 0);
      @(negedge clk);
      chk($sformatf("v%0d_vld", i), get_vld(vec[i].mp), 1);
      chk($sformatf("v%0d_lin", i), get_lin(vec[i].mp), vec[i].lin);
      @(negedge clk);
      chk($sformatf("v%0d_gone", i), get_vld(vec[i].mp), 0);
      if (vec[i].mp) cnt_exp1 = cnt_exp1 + 1; else cnt_exp0 = (cnt_exp0 + 1) % 16;
      chk($sformatf("v%0d_cnt", i), get_cnt(vec[i].mp), vec[i].mp ? cnt_exp1 : cnt_exp0);
    end

    // Backpressure: three back-to-back samples with out_ready low
    bus0.out_ready = 1'b0;
    cnt_before = cnt_exp0;
    drive(0, 1, 0, 3'd1, 4'd1);
    @(negedge clk);
    chk("bp_rdy_after1", bus0.in_ready, 1);
    drive(0, 1, 1, 3'd2, 4'd5);
    @(negedge clk);
    drive(0, 1, 0, 3'd5, 4'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_full_rdy", bus0.in_ready, 0);
      chk("bp_hold_vld", bus0.out_valid, 1);
      chk("bp_hold_lin", bus0.out_linear, 12'h002);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("bp_second", bus0.out_linear, 12'hFEC);
    @(negedge clk);
    chk("bp_third_vld", bus0.out_valid, 1);
    chk("bp_third", bus0.out_linear, 12'h060);
    @(negedge clk);
    chk("bp_empty", bus0.out_valid, 0);
    chk("bp_cnt", bus0.out_count, (cnt_before + 3) % 16);

    // Reset with both stages full
    bus0.out_ready = 1'b0;
    drive(0, 1, 0, 3'd6, 4'd9);
    @(negedge clk);
    drive(0, 1, 1, 3'd4, 4'd7);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("mr_full_rdy", bus0.in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_vld", bus0.out_valid, 0);
    chk("mr_lin", bus0.out_linear, 0);
    chk("mr_cnt", bus0.out_count, 0);
    chk("mr_in_rdy", bus0.in_ready, 1);
    chk("mr_cnt1", bus1.out_count, 0);
    chk("mr_lin1", bus1.out_linear, 0);
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_ghost", bus0.out_valid, 0);
    end

    // Random streaming against the model; count starts at 0 and must wrap
    ntx = 0;
    hold_pending = 0;
    wrap_pending = 0;
    wrap_seen = 0;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      rv = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      rs = 1'($urandom_range(0, 1));
      re = 3'($urandom_range(0, 7));
      rm = 4'($urandom_range(0, 15));
      drive(0, rv, rs, re, rm);
      bus0.out_ready = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (hold_pending) begin
        chk("st_hold_vld", bus0.out_valid, 1);
        chk("st_hold_lin", bus0.out_linear, prev_lin);
        hold_pending = 0;
      end
      if (wrap_pending) begin
        chk("st_wrap", bus0.out_count, 0);
        wrap_pending = 0;
        wrap_seen = 1;
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (q.size() == 0) chk("st_unexpected_out", 1, 0);
        else chk("st_data", bus0.out_linear, q.pop_front());
        if (bus0.out_count == 4'hF) wrap_pending = 1;
        ntx = ntx + 1;
      end else if (bus0.out_valid) begin
        hold_pending = 1;
        prev_lin = bus0.out_linear;
      end
      if (bus0.in_valid && bus0.in_ready) q.push_back(model(0, rs, re, rm));
    end
    @(negedge clk);
    chk("st_drained", q.size(), 0);
    chk("st_cnt", bus0.out_count, ntx);
    chk("st_wrap_seen", wrap_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
